// File: rtl/pixel_mem_mc.sv
// Multi-channel pixel store with valid/ready write and read ports and a back-pressured read response.
// A clear sequencer zeroes one word per cycle; channel 0 occupies the most significant field.
module pixel_mem_mc #(
    parameter int CHANNELS       = 3,
    parameter int CHAN_W         = 8,
    parameter int DEPTH          = 1048576,
    parameter int ADDR_W         = 20,
    parameter int CLEAR_ON_RESET = 1
) (
    input  logic                         Mem_Clk,
    input  logic                         Mem_Reset,
    input  logic                         Mem_Clear,
    output logic                         Mem_Busy,
    input  logic                         Mem_Write_Valid,
    output logic                         Mem_Write_Ready,
    input  logic [ADDR_W-1:0]            Mem_Write_Address,
    input  logic [CHANNELS*CHAN_W-1:0]   Mem_Input_Data,
    input  logic [CHANNELS-1:0]          Mem_Write_Chan_En,
    input  logic                         Mem_Read_Valid,
    output logic                         Mem_Read_Ready,
    input  logic [ADDR_W-1:0]            Mem_Read_Address,
    output logic                         Mem_Output_Valid,
    input  logic                         Mem_Output_Ready,
    output logic [CHANNELS*CHAN_W-1:0]   Mem_Output_Data,
    output logic                         Mem_Addr_Error
);

    localparam int WORD_W = CHANNELS * CHAN_W;
    localparam int IDX_W  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_CLEAR = 1'b1
    } state_t;

    state_t              state_r;
    state_t              state_next_s;
    logic [IDX_W-1:0]    clr_cnt_r;
    logic [IDX_W-1:0]    clr_cnt_next_s;
    logic [WORD_W-1:0]   mem_r [0:DEPTH-1];

    logic                out_valid_r;
    logic [WORD_W-1:0]   out_data_r;
    logic                addr_err_r;

    logic                idle_s;
    logic                wr_acc_s;
    logic                rd_acc_s;
    logic                wr_ok_s;
    logic                rd_ok_s;
    logic [IDX_W-1:0]    wr_idx_s;
    logic [IDX_W-1:0]    rd_idx_s;
    logic [WORD_W-1:0]   wr_word_s;
    logic [WORD_W-1:0]   rd_word_s;
    logic                mem_we_s;
    logic [IDX_W-1:0]    mem_widx_s;
    logic [WORD_W-1:0]   mem_wdata_s;

    function automatic logic in_range(input logic [ADDR_W-1:0] addr);
        return (32'(addr) < 32'(DEPTH));
    endfunction

    // Replace only the enabled channel fields of old_word with those of new_word.
    function automatic logic [WORD_W-1:0] merge_chan(input logic [WORD_W-1:0]   old_word,
                                                     input logic [WORD_W-1:0]   new_word,
                                                     input logic [CHANNELS-1:0] en);
        logic [WORD_W-1:0] res;
        res = old_word;
        for (int k = 0; k < CHANNELS; k++) begin
            if (en[k]) begin
                res[(CHANNELS-k)*CHAN_W-1 -: CHAN_W] = new_word[(CHANNELS-k)*CHAN_W-1 -: CHAN_W];
            end else begin
                res[(CHANNELS-k)*CHAN_W-1 -: CHAN_W] = old_word[(CHANNELS-k)*CHAN_W-1 -: CHAN_W];
            end
        end
        return res;
    endfunction

    assign idle_s          = (state_r == ST_IDLE);
    assign Mem_Write_Ready = idle_s & ~Mem_Clear;
    assign Mem_Read_Ready  = idle_s & ~Mem_Clear & (~out_valid_r | Mem_Output_Ready);
    assign wr_acc_s        = Mem_Write_Valid & Mem_Write_Ready;
    assign rd_acc_s        = Mem_Read_Valid & Mem_Read_Ready;
    assign wr_ok_s         = in_range(Mem_Write_Address);
    assign rd_ok_s         = in_range(Mem_Read_Address);
    assign wr_idx_s        = Mem_Write_Address[IDX_W-1:0];
    assign rd_idx_s        = Mem_Read_Address[IDX_W-1:0];
    assign wr_word_s       = merge_chan(mem_r[wr_idx_s], Mem_Input_Data, Mem_Write_Chan_En);

    assign Mem_Busy         = (state_r == ST_CLEAR);
    assign Mem_Output_Valid = out_valid_r;
    assign Mem_Output_Data  = out_data_r;
    assign Mem_Addr_Error   = addr_err_r;

    // Read data selection: out-of-range reads return zero, same-address reads see the write (write-first).
    always_comb begin
        rd_word_s = {WORD_W{1'b0}};
        if (!rd_ok_s) begin
            rd_word_s = {WORD_W{1'b0}};
        end else if (wr_acc_s && wr_ok_s && (Mem_Write_Address == Mem_Read_Address)) begin
            rd_word_s = wr_word_s;
        end else begin
            rd_word_s = mem_r[rd_idx_s];
        end
    end

    // Array write port arbitration between the clear sequencer and accepted writes.
    always_comb begin
        mem_we_s    = 1'b0;
        mem_widx_s  = wr_idx_s;
        mem_wdata_s = wr_word_s;
        if (!Mem_Reset) begin
            mem_we_s = 1'b0;
        end else if (state_r == ST_CLEAR) begin
            mem_we_s    = 1'b1;
            mem_widx_s  = clr_cnt_r;
            mem_wdata_s = {WORD_W{1'b0}};
        end else if (wr_acc_s && wr_ok_s) begin
            mem_we_s = 1'b1;
        end else begin
            mem_we_s = 1'b0;
        end
    end

    // Pixel array storage; contents are not reset, the clear sequencer zeroes them.
    always_ff @(posedge Mem_Clk) begin
        if (mem_we_s) begin
            mem_r[mem_widx_s] <= mem_wdata_s;
        end
    end

    // Next-state logic for the idle/clear sequencer.
    always_comb begin
        state_next_s   = state_r;
        clr_cnt_next_s = clr_cnt_r;
        case (state_r)
            ST_IDLE: begin
                if (Mem_Clear) begin
                    state_next_s   = ST_CLEAR;
                    clr_cnt_next_s = {IDX_W{1'b0}};
                end else begin
                    state_next_s   = ST_IDLE;
                end
            end
            ST_CLEAR: begin
                if (clr_cnt_r == IDX_W'(DEPTH - 1)) begin
                    state_next_s   = ST_IDLE;
                    clr_cnt_next_s = {IDX_W{1'b0}};
                end else begin
                    clr_cnt_next_s = clr_cnt_r + IDX_W'(1);
                end
            end
            default: begin
                state_next_s   = ST_IDLE;
                clr_cnt_next_s = {IDX_W{1'b0}};
            end
        endcase
    end

    // Sequencer state register with synchronous active-low reset.
    always_ff @(posedge Mem_Clk) begin
        if (!Mem_Reset) begin
            state_r   <= (CLEAR_ON_RESET != 0) ? ST_CLEAR : ST_IDLE;
            clr_cnt_r <= {IDX_W{1'b0}};
        end else begin
            state_r   <= state_next_s;
            clr_cnt_r <= clr_cnt_next_s;
        end
    end

    // Read response register: loads on accept, drops valid on take, otherwise holds.
    always_ff @(posedge Mem_Clk) begin
        if (!Mem_Reset) begin
            out_valid_r <= 1'b0;
            out_data_r  <= {WORD_W{1'b0}};
            addr_err_r  <= 1'b0;
        end else begin
            addr_err_r <= (wr_acc_s & ~wr_ok_s) | (rd_acc_s & ~rd_ok_s);
            if (rd_acc_s) begin
                out_valid_r <= 1'b1;
                out_data_r  <= rd_word_s;
            end else if (Mem_Output_Ready) begin
                out_valid_r <= 1'b0;
            end else begin
                out_valid_r <= out_valid_r;
            end
        end
    end

endmodule

// File: tb/tb_pixel_mem_mc.sv
// Bench for pixel_mem_mc (DEPTH=16): directed steps followed by random traffic,
// each compared against an array-based reference model of the pixel store.
module tb_pixel_mem_mc;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst_l;
    logic        clr;
    logic        busy;
    logic        wv, wrdy, rv, rrdy, ov, ordy, aerr;
    logic [4:0]  wa, ra;
    logic [23:0] wd, od;
    logic [2:0]  we;

    int checks = 0;
    int errors = 0;

    logic [23:0] model [DEPTH];
    int          clear_left = 0;
    logic        exp_valid  = 1'b0;
    logic [23:0] exp_data   = 24'h0;
    logic        exp_err    = 1'b0;

    pixel_mem_mc #(
        .CHANNELS(3), .CHAN_W(8), .DEPTH(DEPTH), .ADDR_W(5), .CLEAR_ON_RESET(1)
    ) dut (
        .Mem_Clk(clk), .Mem_Reset(rst_l), .Mem_Clear(clr), .Mem_Busy(busy),
        .Mem_Write_Valid(wv), .Mem_Write_Ready(wrdy), .Mem_Write_Address(wa),
        .Mem_Input_Data(wd), .Mem_Write_Chan_En(we),
        .Mem_Read_Valid(rv), .Mem_Read_Ready(rrdy), .Mem_Read_Address(ra),
        .Mem_Output_Valid(ov), .Mem_Output_Ready(ordy), .Mem_Output_Data(od),
        .Mem_Addr_Error(aerr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check readys, advance the model across the edge, check outputs.
    task automatic cycle(input logic v_w, input logic [4:0] a_w, input logic [23:0] d_w,
                         input logic [2:0] e_w, input logic v_r, input logic [4:0] a_r,
                         input logic o_r, input logic c, input logic r);
        logic wr_rdy_e, rd_rdy_e, wacc, racc;
        wv = v_w; wa = a_w; wd = d_w; we = e_w;
        rv = v_r; ra = a_r; ordy = o_r; clr = c; rst_l = r;
        #1;
        wr_rdy_e = (clear_left == 0) && !c;
        rd_rdy_e = wr_rdy_e && (!exp_valid || o_r);
        if (r) begin
            chk("write_ready", wrdy, wr_rdy_e);
            chk("read_ready", rrdy, rd_rdy_e);
        end
        @(posedge clk);
        if (!r) begin
            exp_valid  = 1'b0;
            exp_data   = 24'h0;
            exp_err    = 1'b0;
            clear_left = DEPTH;
        end else begin
            wacc = v_w && wr_rdy_e;
            racc = v_r && rd_rdy_e;
            if (clear_left > 0) begin
                model[DEPTH - clear_left] = 24'h0;
                clear_left--;
            end else if (c) begin
                clear_left = DEPTH;
            end
            if (wacc && a_w < DEPTH) begin
                for (int k = 0; k < 3; k++) begin
                    if (e_w[k]) model[a_w][(2-k)*8 +: 8] = d_w[(2-k)*8 +: 8];
                end
            end
            exp_err = (wacc && a_w >= DEPTH) || (racc && a_r >= DEPTH);
            if (racc) begin
                exp_valid = 1'b1;
                exp_data  = (a_r < DEPTH) ? model[a_r] : 24'h0;
            end else if (exp_valid && o_r) begin
                exp_valid = 1'b0;
            end
        end
        #1;
        chk("busy", busy, clear_left > 0);
        chk("out_valid", ov, exp_valid);
        chk("out_data", od, exp_data);
        chk("addr_error", aerr, exp_err);
    endtask

    task automatic idle(input logic o_r);
        cycle(1'b0, 5'd0, 24'h0, 3'b000, 1'b0, 5'd0, o_r, 1'b0, 1'b1);
    endtask

    initial begin
        wv = 1'b0; wa = 5'd0; wd = 24'h0; we = 3'b000;
        rv = 1'b0; ra = 5'd0; ordy = 1'b0; clr = 1'b0; rst_l = 1'b1;
        for (int i = 0; i < DEPTH; i++) model[i] = 24'h0;

        // Reset then the full 16-cycle clear; readys must stay low throughout.
        cycle(1'b0, 5'd0, 24'h0, 3'b000, 1'b0, 5'd0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) idle(1'b1);
        chk("busy_done", busy, 1'b0);

        // Every word reads back zero, back to back.
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 5'd0, 24'h0, 3'b000, 1'b1, 5'(i), 1'b1, 1'b0, 1'b1);
        idle(1'b1);

        // Full write, read next cycle, then partial write with same-cycle read (write-first merge).
        cycle(1'b1, 5'd5, 24'hAABBCC, 3'b111, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 5'd0, 24'h0, 3'b000, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1);
        chk("read5_full", od, 24'hAABBCC);
        cycle(1'b1, 5'd5, 24'h112233, 3'b010, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1);
        chk("read5_merge", od, 24'hAA22CC);

        // Back-pressure: data held while not taken, then a new read with no bubble.
        cycle(1'b1, 5'd3, 24'h030303, 3'b111, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 5'd4, 24'h040404, 3'b111, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 5'd0, 24'h0, 3'b000, 1'b1, 5'd3, 1'b0, 1'b0, 1'b1);
        for (int i = 0; i < 4; i++) cycle(1'b0, 5'd0, 24'h0, 3'b000, 1'b1, 5'd4, 1'b0, 1'b0, 1'b1);
        chk("held_data", od, 24'h030303);
        cycle(1'b0, 5'd0, 24'h0, 3'b000, 1'b1, 5'd4, 1'b1, 1'b0, 1'b1);
        chk("no_bubble_valid", ov, 1'b1);
        chk("no_bubble_data", od, 24'h040404);
        idle(1'b1);

        // Out-of-range accesses: write dropped, read zero, one error pulse per access cycle.
        cycle(1'b1, 5'd16, 24'hDEADBE, 3'b111, 1'b0, 5'd0, 1'b1, 1'b0, 1'b1);
        chk("oor_write_err", aerr, 1'b1);
        idle(1'b1);
        cycle(1'b0, 5'd0, 24'h0, 3'b000, 1'b1, 5'd16, 1'b1, 1'b0, 1'b1);
        chk("oor_read_data", od, 24'h0);
        cycle(1'b1, 5'd17, 24'h123456, 3'b111, 1'b1, 5'd16, 1'b1, 1'b0, 1'b1);
        idle(1'b1);
        cycle(1'b0, 5'd0, 24'h0, 3'b000, 1'b1, 5'd0, 1'b1, 1'b0, 1'b1);
        chk("word0_untouched", od, 24'h0);

        // Clear mid-stream, then reset partway through the clear.
        cycle(1'b1, 5'd7, 24'h777777, 3'b111, 1'b1, 5'd5, 1'b0, 1'b1, 1'b1);
        for (int i = 0; i < 6; i++) cycle(1'b1, 5'd8, 24'h888888, 3'b111, 1'b1, 5'd5, 1'b1, 1'b0, 1'b1);
        cycle(1'b0, 5'd0, 24'h0, 3'b000, 1'b1, 5'd5, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 5'd9, 24'h999999, 3'b111, 1'b1, 5'd9, 1'b1, 1'b0, 1'b1);
        chk("busy_after_reset_clear", busy, 1'b0);
        for (int i = 0; i < DEPTH; i++) cycle(1'b0, 5'd0, 24'h0, 3'b000, 1'b1, 5'(i), 1'b1, 1'b0, 1'b1);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            cycle(1'($urandom_range(0, 1)), 5'($urandom_range(0, 19)), 24'($urandom),
                  3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 19)),
                  1'($urandom_range(0, 3) != 0), 1'($urandom_range(0, 79) == 0),
                  1'($urandom_range(0, 249) != 0));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
